vector_line_engine: RTL and testbench

- Parametrised, pipelined successor to the current single-shot line drawer in the vector rasteriser.
- Accepts line commands (start, end, intensity) over a valid/ready handshake, with one command of look-ahead buffering.
- Walks each line with exact integer Bresenham, emitting one pixel per cycle over a stallable valid/ready pixel port.
- Clips pixels to a parametrised window and supports abort; feeds the framebuffer write arbiter.

---
 rtl/vector_line_engine_if.sv | 22 ++
 rtl/vector_line_engine.sv | 148 ++++++++++++++
 tb/tb_vector_line_engine.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_line_engine_if.sv
// vector_line_engine_if: handshake bundle for vector_line_engine
//   cmd_valid/cmd_ready, cmd_x0/y0/x1/y1, cmd_z : line command (start, end, intensity)
//   pix_valid/pix_ready, pix_x/y, pix_z, pix_last : pixel stream to the framebuffer arbiter
interface vector_line_engine_if #(
  parameter int CW = 10,
  parameter int ZW = 4
);
  logic          cmd_valid, cmd_ready;
  logic [CW-1:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic [ZW-1:0] cmd_z;
  logic          pix_valid, pix_ready, pix_last;
  logic [CW-1:0] pix_x, pix_y;
  logic [ZW-1:0] pix_z;
  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_z, pix_ready,
    input  cmd_ready, pix_valid, pix_x, pix_y, pix_z, pix_last
  );
  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_z, pix_ready,
    output cmd_ready, pix_valid, pix_x, pix_y, pix_z, pix_last
  );
endinterface

// File: rtl/vector_line_engine.sv
// vector_line_engine: Bresenham line walker with one-deep command slot, window clipping and abort
//   pclk, reset_l : clock, async active-low reset
//   abort         : drops the active line and the pending command
//   bus (slave)   : command in (valid/ready), pixel out (valid/ready, last)
//   line_done     : one-cycle pulse per finished line; busy : engine active or slot full
module vector_line_engine #(
  parameter int CW   = 10,
  parameter int ZW   = 4,
  parameter int XMAX = 1023,
  parameter int YMAX = 767
) (
  input  logic                 pclk,
  input  logic                 reset_l,
  input  logic                 abort,
  vector_line_engine_if.slave  bus,
  output logic                 line_done,
  output logic                 busy
);
  localparam int EW = CW + 2;
  localparam logic [CW:0] XLIM = XMAX[CW:0];
  localparam logic [CW:0] YLIM = YMAX[CW:0];
  typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;
  typedef struct packed {
    logic [CW-1:0] x0, y0, x1, y1;
    logic [ZW-1:0] z;
  } cmd_t;
  state_t               state_q, state_d;
  cmd_t                 pend_q, pend_d, cur_q, cur_d, cmd_in, src;
  logic                 pend_full_q, pend_full_d;
  logic [CW-1:0]        x_q, x_d, y_q, y_d;
  logic signed [EW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic signed [EW-1:0] ddx, ddy, adx, ady, e2;
  logic                 sx_q, sx_d, sy_q, sy_d;
  logic                 pix_valid_q, pix_valid_d, pix_last_q, pix_last_d;
  logic                 line_done_q, line_done_d;
  logic                 hs, avail, adv, at_end, take;
  function automatic logic visible(input logic [CW-1:0] px, input logic [CW-1:0] py);
    return ({1'b0, px} <= XLIM) && ({1'b0, py} <= YLIM);
  endfunction
  assign cmd_in        = {bus.cmd_x0, bus.cmd_y0, bus.cmd_x1, bus.cmd_y1, bus.cmd_z};
  assign bus.cmd_ready = !pend_full_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_x     = x_q;
  assign bus.pix_y     = y_q;
  assign bus.pix_z     = cur_q.z;
  assign bus.pix_last  = pix_last_q;
  assign line_done     = line_done_q;
  assign busy          = (state_q != IDLE) || pend_full_q;
  always_comb begin
    hs     = bus.cmd_valid && !pend_full_q && !abort;
    avail  = pend_full_q || hs;
    src    = pend_full_q ? pend_q : cmd_in;
    at_end = (x_q == cur_q.x1) && (y_q == cur_q.y1);
    // clipped pixels never wait for the downstream
    adv    = (state_q == DRAW) && (!pix_valid_q || bus.pix_ready);
    take   = avail && ((state_q == IDLE) || (adv && at_end));
    ddx    = $signed({2'b00, cur_q.x1}) - $signed({2'b00, cur_q.x0});
    ddy    = $signed({2'b00, cur_q.y1}) - $signed({2'b00, cur_q.y0});
    adx    = ddx[EW-1] ? -ddx : ddx;
    ady    = ddy[EW-1] ? -ddy : ddy;
    e2     = err_q <<< 1;
    state_d     = state_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    cur_d       = cur_q;
    x_d         = x_q;
    y_d         = y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    err_d       = err_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    line_done_d = 1'b0;
    // a slot entry is consumed in the same cycle it is taken, so the slot never blocks a direct load
    if (take) begin
      cur_d       = src;
      state_d     = SETUP;
      pend_full_d = 1'b0;
    end else if (hs) begin
      pend_d      = cmd_in;
      pend_full_d = 1'b1;
    end
    if (state_q == SETUP) begin
      x_d     = cur_q.x0;
      y_d     = cur_q.y0;
      dx_d    = adx;
      dy_d    = -ady;
      err_d   = adx - ady;
      sx_d    = cur_q.x0 < cur_q.x1;
      sy_d    = cur_q.y0 < cur_q.y1;
      state_d = DRAW;
    end else if (adv) begin
      if (at_end) begin
        line_done_d = 1'b1;
        state_d     = take ? SETUP : IDLE;
      end else begin
        // both tests use the pre-step error term
        if (e2 >= dy_q) begin
          err_d = err_q + dy_q;
          x_d   = sx_q ? x_q + CW'(1) : x_q - CW'(1);
        end
        if (e2 <= dx_q) begin
          err_d = err_d + dx_q;
          y_d   = sy_q ? y_q + CW'(1) : y_q - CW'(1);
        end
      end
    end
    if (abort) begin
      state_d     = IDLE;
      pend_full_d = 1'b0;
      line_done_d = 1'b0;
    end
    pix_valid_d = (state_d == DRAW) && visible(x_d, y_d);
    pix_last_d  = pix_valid_d && (x_d == cur_d.x1) && (y_d == cur_d.y1);
  end
  always_ff @(posedge pclk or negedge reset_l)
    if (!reset_l) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      cur_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      err_q       <= '0;
      sx_q        <= 1'b0;
      sy_q        <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      cur_q       <= cur_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      err_q       <= err_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      pix_valid_q <= pix_valid_d;
      pix_last_q  <= pix_last_d;
      line_done_q <= line_done_d;
    end
endmodule

// File: tb/tb_vector_line_engine.sv
// tb_vector_line_engine: directed checks of vector_line_engine (wide window DUT and XMAX=3 clip DUT)
module tb_vector_line_engine;
  localparam int CW = 10;
  localparam int ZW = 4;
  typedef struct {int x; int y; int z; int last; int c;} pix_t;
  logic pclk = 1'b0, reset_l = 1'b0, abort = 1'b0, pix_ready = 1'b1, cmd_valid = 1'b0;
  logic tog = 1'b0, sel = 1'b0;
  logic [CW-1:0] cx0 = '0, cy0 = '0, cx1 = '0, cy1 = '0;
  logic [ZW-1:0] cz = '0;
  logic done_a, busy_a, done_b, busy_b;
  logic o_valid, o_ready, o_last, o_busy, o_done;
  logic [CW-1:0] o_x, o_y;
  logic [ZW-1:0] o_z;
  int cyc = 0, errors = 0, checks = 0;
  int vcnt = 0, lastcnt = 0, stalls = 0, stall_bad = 0;
  logic prev_stall = 1'b0;
  logic [CW-1:0] px = '0, py = '0;
  pix_t pixq[$];
  int doneq[$];
  int ex[$];
  int h, h2, h3, b, d, v0, l0, s0, sb0;
  vector_line_engine_if #(.CW(CW), .ZW(ZW)) ia ();
  vector_line_engine_if #(.CW(CW), .ZW(ZW)) ib ();
  assign ia.cmd_valid = cmd_valid;
  assign ia.cmd_x0 = cx0;
  assign ia.cmd_y0 = cy0;
  assign ia.cmd_x1 = cx1;
  assign ia.cmd_y1 = cy1;
  assign ia.cmd_z = cz;
  assign ia.pix_ready = pix_ready;
  assign ib.cmd_valid = cmd_valid;
  assign ib.cmd_x0 = cx0;
  assign ib.cmd_y0 = cy0;
  assign ib.cmd_x1 = cx1;
  assign ib.cmd_y1 = cy1;
  assign ib.cmd_z = cz;
  assign ib.pix_ready = pix_ready;
  vector_line_engine #(.CW(CW), .ZW(ZW), .XMAX(1023), .YMAX(767)) u_dut (
    .pclk(pclk), .reset_l(reset_l), .abort(abort), .bus(ia), .line_done(done_a), .busy(busy_a)
  );
  vector_line_engine #(.CW(CW), .ZW(ZW), .XMAX(3), .YMAX(3)) u_clip (
    .pclk(pclk), .reset_l(reset_l), .abort(abort), .bus(ib), .line_done(done_b), .busy(busy_b)
  );
  assign o_valid = sel ? ib.pix_valid : ia.pix_valid;
  assign o_ready = sel ? ib.cmd_ready : ia.cmd_ready;
  assign o_last  = sel ? ib.pix_last : ia.pix_last;
  assign o_x     = sel ? ib.pix_x : ia.pix_x;
  assign o_y     = sel ? ib.pix_y : ia.pix_y;
  assign o_z     = sel ? ib.pix_z : ia.pix_z;
  assign o_busy  = sel ? busy_b : busy_a;
  assign o_done  = sel ? done_b : done_a;
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;
  initial forever begin
    @(posedge pclk);
    #2;
    pix_ready = tog ? !pix_ready : 1'b1;
  end
  always @(negedge pclk) begin
    if (o_valid && pix_ready) begin
      pix_t p;
      p.x = int'(o_x);
      p.y = int'(o_y);
      p.z = int'(o_z);
      p.last = int'(o_last);
      p.c = cyc;
      pixq.push_back(p);
    end
    if (o_done) doneq.push_back(cyc);
    vcnt <= vcnt + int'(o_valid);
    lastcnt <= lastcnt + int'(o_last);
    stalls <= stalls + int'(o_valid && !pix_ready);
    if (prev_stall && (!o_valid || o_x != px || o_y != py)) stall_bad <= stall_bad + 1;
    prev_stall <= o_valid && !pix_ready;
    px <= o_x;
    py <= o_y;
  end
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic send(input int x0, input int y0, input int x1, input int y1, input int z, output int hc);
    int n = 0;
    @(negedge pclk);
    cx0 = CW'(x0);
    cy0 = CW'(y0);
    cx1 = CW'(x1);
    cy1 = CW'(y1);
    cz = ZW'(z);
    cmd_valid = 1'b1;
    while (!o_ready && n < 50) begin
      @(negedge pclk);
      n++;
    end
    check("send_bound", int'(n < 50), 1);
    hc = cyc;
    @(posedge pclk);
    #1;
    cmd_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    @(negedge pclk);
    while ((o_busy || o_valid) && n < 300) begin
      @(negedge pclk);
      n++;
    end
    check("idle_bound", int'(n < 300), 1);
    @(negedge pclk);
  endtask
  task automatic do_reset();
    @(negedge pclk);
    reset_l = 1'b0;
    repeat (2) @(negedge pclk);
    reset_l = 1'b1;
  endtask
  task automatic check_line(input string tag, input int base, input int hc, input int n, input int seg,
                            input int ez, input int timed);
    check({tag, "_count"}, pixq.size() - base, n);
    for (int i = 0; i < n && base + i < pixq.size(); i++) begin
      check($sformatf("%s_xy%0d", tag, i), pixq[base+i].x * 1024 + pixq[base+i].y, ex[2*i] * 1024 + ex[2*i+1]);
      check($sformatf("%s_z%0d", tag, i), pixq[base+i].z, ez);
      check($sformatf("%s_last%0d", tag, i), pixq[base+i].last, int'(i % seg == seg - 1));
      if (timed != 0) check($sformatf("%s_cyc%0d", tag, i), pixq[base+i].c, hc + 2 + i);
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(negedge pclk);
    check("rst_cmd_ready", int'(o_ready), 1);
    check("rst_pix_valid", int'(o_valid), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_line_done", int'(o_done), 0);
    check("rst_pix_last", int'(o_last), 0);
    check("rst_pix_x", int'(o_x), 0);
    check("rst_pix_z", int'(o_z), 0);
    reset_l = 1'b1;
    // 1: shallow line
    b = pixq.size(); d = doneq.size();
    send(0, 0, 5, 2, 7, h);
    wait_idle();
    ex = '{0,0, 1,0, 2,1, 3,1, 4,2, 5,2};
    check_line("t1", b, h, 6, 6, 7, 1);
    check("t1_done_n", doneq.size() - d, 1);
    if (doneq.size() > d) check("t1_done_cyc", doneq[d], h + 8);
    // 2: reverse line, then a dot
    b = pixq.size();
    send(5, 2, 0, 0, 12, h);
    wait_idle();
    ex = '{5,2, 4,2, 3,1, 2,1, 1,0, 0,0};
    check_line("t2r", b, h, 6, 6, 12, 1);
    b = pixq.size(); d = doneq.size();
    send(9, 9, 9, 9, 5, h);
    wait_idle();
    ex = '{9,9};
    check_line("t2d", b, h, 1, 1, 5, 1);
    if (doneq.size() > d) check("t2d_done_cyc", doneq[d], h + 3);
    check("t2d_done_n", doneq.size() - d, 1);
    // 3: diagonal with stalling downstream
    b = pixq.size(); s0 = stalls; sb0 = stall_bad;
    tog = 1'b1;
    send(0, 0, 3, 3, 1, h);
    wait_idle();
    tog = 1'b0;
    ex = '{0,0, 1,1, 2,2, 3,3};
    check_line("t3", b, h, 4, 4, 1, 0);
    check("t3_stalls_seen", int'(stalls > s0), 1);
    check("t3_stall_stable", stall_bad - sb0, 0);
    // 4: three back-to-back commands
    repeat (2) @(negedge pclk);
    b = pixq.size(); d = doneq.size();
    send(0, 0, 2, 0, 3, h);
    send(10, 5, 10, 7, 3, h2);
    send(20, 20, 22, 22, 3, h3);
    wait_idle();
    check("t4_hs_second", h2, h + 1);
    check("t4_hs_third", h3, h + 5);
    ex = '{0,0, 1,0, 2,0, 10,5, 10,6, 10,7, 20,20, 21,21, 22,22};
    check_line("t4", b, h, 9, 3, 3, 0);
    if (pixq.size() >= b + 9) begin
      check("t4_cyc_a", pixq[b].c, h + 2);
      check("t4_cyc_b", pixq[b+3].c, h + 6);
      check("t4_cyc_c", pixq[b+6].c, h + 10);
    end
    check("t4_done_n", doneq.size() - d, 3);
    if (doneq.size() >= d + 3) begin
      check("t4_done_a", doneq[d], h + 5);
      check("t4_done_b", doneq[d+1], h + 9);
      check("t4_done_c", doneq[d+2], h + 13);
    end
    // 5: clipping against XMAX=3
    do_reset();
    sel = 1'b1;
    @(negedge pclk);
    b = pixq.size(); d = doneq.size(); v0 = vcnt; l0 = lastcnt;
    send(2, 0, 6, 0, 9, h);
    wait_idle();
    ex = '{2,0, 3,0};
    check("t5_count", pixq.size() - b, 2);
    if (pixq.size() >= b + 2) begin
      check("t5_xy0", pixq[b].x * 1024 + pixq[b].y, 2 * 1024);
      check("t5_xy1", pixq[b+1].x * 1024 + pixq[b+1].y, 3 * 1024);
      check("t5_cyc1", pixq[b+1].c, h + 3);
    end
    check("t5_valid_cycles", vcnt - v0, 2);
    check("t5_last_cycles", lastcnt - l0, 0);
    check("t5_done_n", doneq.size() - d, 1);
    if (doneq.size() > d) check("t5_done_cyc", doneq[d], h + 7);
    // 6: abort on the third pixel with a pending command
    do_reset();
    sel = 1'b0;
    @(negedge pclk);
    b = pixq.size(); d = doneq.size();
    send(0, 0, 9, 0, 2, h);
    send(0, 5, 3, 5, 4, h2);
    check("t6_hs_pend", h2, h + 1);
    check("t6_ready_low", int'(o_ready), 0);
    while (cyc < h + 4) begin
      @(posedge pclk);
      #1;
    end
    abort = 1'b1;
    @(posedge pclk);
    #1;
    abort = 1'b0;
    @(negedge pclk);
    check("t6_valid_after", int'(o_valid), 0);
    check("t6_busy_after", int'(o_busy), 0);
    check("t6_ready_after", int'(o_ready), 1);
    repeat (10) @(negedge pclk);
    check("t6_pix_count", pixq.size() - b, 3);
    if (pixq.size() >= b + 3) check("t6_third_x", pixq[b+2].x, 2);
    check("t6_done_n", doneq.size() - d, 0);
    // reset in the middle of a line
    b = pixq.size(); d = doneq.size();
    send(0, 0, 9, 9, 6, h);
    repeat (3) @(negedge pclk);
    reset_l = 1'b0;
    @(negedge pclk);
    check("rst_mid_valid", int'(o_valid), 0);
    check("rst_mid_busy", int'(o_busy), 0);
    reset_l = 1'b1;
    v0 = pixq.size();
    repeat (8) @(negedge pclk);
    check("rst_mid_no_pix", pixq.size() - v0, 0);
    check("rst_mid_no_done", doneq.size() - d, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
